// File: rtl/swim_pkg.sv
// SWIM low-speed transmit: shared state encoding, frame sizes and timing.
// Optional resend-on-NACK support is enabled with SWIM_TX_RETRY_EN.
package swim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_ACK_WAIT,
    S_ACK_LOW,
    S_DONE,
    S_GAP
  } swim_state_e;

  localparam logic [3:0] CMD_BITS  = 4'd5;
  localparam logic [3:0] DATA_BITS = 4'd10;
  localparam int ACK_SWIM          = 11;

  localparam int DEF_CLKS_PER_SWIM = 6;
  localparam int DEF_BIT_SWIM      = 22;
  localparam int DEF_SHORT_SWIM    = 2;
  localparam int DEF_ACK_TIMEOUT   = 2048;

  // Frame left-justified in 10 bits: header, payload MSB first, parity.
  function automatic logic [9:0] frame_word(
    input logic [7:0] d,
    input logic       cmd
  );
    if (cmd)
      return {1'b0, d[2:0], ^d[2:0], 5'b0};
    return {1'b0, d, ^d};
  endfunction

endpackage

// File: rtl/swim_byte_tx_if.sv
// Upstream byte handshake into the SWIM transmitter.
// Optional resend-on-NACK support is enabled with SWIM_TX_RETRY_EN.
interface swim_byte_tx_if;
  logic [7:0] in_data;
  logic       in_cmd;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_cmd,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_cmd,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/swim_sync.sv
// Two-flop synchronizer for the SWIM line with edge detect.
// Optional resend-on-NACK support is enabled with SWIM_TX_RETRY_EN.
module swim_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic fall,
  output logic rise
);

  logic s1, s2, s3;

  // Idle line is high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;

endmodule

// File: rtl/swim_byte_tx.sv
// SWIM low-speed frame transmitter with target ACK sampling.
// Optional resend-on-NACK support is enabled with SWIM_TX_RETRY_EN.
module swim_byte_tx
  import swim_pkg::*;
#(
  parameter int CLKS_PER_SWIM = DEF_CLKS_PER_SWIM,
  parameter int BIT_SWIM      = DEF_BIT_SWIM,
  parameter int SHORT_SWIM    = DEF_SHORT_SWIM,
  parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  swim_byte_tx_if.slave  up,
  output logic           swim_drive_low,
  input  logic           swim_in,
  output logic           done,
  output logic           ack_ok,
  output logic           timeout,
`ifdef SWIM_TX_RETRY_EN
  output logic [1:0]     retry_cnt,
`endif
  output logic           busy
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  localparam logic [7:0] T_M1 =
    8'(BIT_SWIM * CLKS_PER_SWIM - 1);
  localparam logic [7:0] LONG_M1 =
    8'((BIT_SWIM - SHORT_SWIM) * CLKS_PER_SWIM - 1);
  localparam logic [7:0] SHORT_M1 =
    8'(SHORT_SWIM * CLKS_PER_SWIM - 1);
  localparam logic [7:0] ACK_LIM =
    8'(ACK_SWIM * CLKS_PER_SWIM);
  localparam logic [TW-1:0] TO_M1 =
    TW'(ACK_TIMEOUT - 1);

  swim_state_e   state, state_n;
  logic [7:0]    cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [9:0]    sh, sh_n;
  logic [3:0]    left, left_n;
  logic          ack_q, ack_n;
  logic          to_q, to_n;
  logic          drive_q, ready_q, done_q;
  logic          ack_res;

`ifdef SWIM_TX_RETRY_EN
  logic [9:0]    frame, frame_n;
  logic [3:0]    nbits, nbits_n;
  logic [1:0]    retry, retry_n;
`endif

  logic line_s, line_fall, line_rise;

  swim_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (swim_in),
    .q     (line_s),
    .fall  (line_fall),
    .rise  (line_rise)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tcnt_n  = tcnt;
    sh_n    = sh;
    left_n  = left;
    ack_n   = ack_q;
    to_n    = to_q;
    ack_res = 1'b0;
`ifdef SWIM_TX_RETRY_EN
    frame_n = frame;
    nbits_n = nbits;
    retry_n = retry;
`endif
    unique case (state)
      S_IDLE: begin
        if (up.in_valid && ready_q) begin
          sh_n    = frame_word(up.in_data, up.in_cmd);
          left_n  = up.in_cmd ? CMD_BITS : DATA_BITS;
          cnt_n   = 8'd0;
          state_n = S_LOW;
`ifdef SWIM_TX_RETRY_EN
          frame_n = sh_n;
          nbits_n = left_n;
          retry_n = 2'd0;
`endif
        end
      end
      S_LOW: begin
        cnt_n = cnt + 8'd1;
        if (cnt == (sh[9] ? SHORT_M1 : LONG_M1))
          state_n = S_HIGH;
      end
      S_HIGH: begin
        if (cnt == T_M1) begin
          cnt_n = 8'd0;
          if (left > 4'd1) begin
            sh_n    = {sh[8:0], 1'b0};
            left_n  = left - 4'd1;
            state_n = S_LOW;
          end else begin
            tcnt_n  = '0;
            state_n = S_ACK_WAIT;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_ACK_WAIT: begin
        if (line_fall) begin
          cnt_n   = 8'd0;
          state_n = S_ACK_LOW;
        end else if (tcnt == TO_M1) begin
          ack_n   = 1'b0;
          to_n    = 1'b1;
          state_n = S_DONE;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      S_ACK_LOW: begin
        if (line_rise || cnt == T_M1) begin
          ack_res = line_s && (cnt < ACK_LIM);
          state_n = S_DONE;
`ifdef SWIM_TX_RETRY_EN
          if (!ack_res && retry != 2'd3) begin
            retry_n = retry + 2'd1;
            cnt_n   = 8'd0;
            state_n = S_GAP;
          end
`endif
          if (state_n == S_DONE) begin
            ack_n = ack_res;
            to_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
`ifdef SWIM_TX_RETRY_EN
      S_GAP: begin
        if (cnt == T_M1) begin
          sh_n    = frame;
          left_n  = nbits;
          cnt_n   = 8'd0;
          state_n = S_LOW;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
`endif
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      tcnt    <= '0;
      sh      <= 10'd0;
      left    <= 4'd0;
      ack_q   <= 1'b0;
      to_q    <= 1'b0;
      drive_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef SWIM_TX_RETRY_EN
      frame   <= 10'd0;
      nbits   <= 4'd0;
      retry   <= 2'd0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      tcnt    <= tcnt_n;
      sh      <= sh_n;
      left    <= left_n;
      ack_q   <= ack_n;
      to_q    <= to_n;
      drive_q <= (state_n == S_LOW);
      ready_q <= (state_n == S_IDLE);
      done_q  <= (state_n == S_DONE);
`ifdef SWIM_TX_RETRY_EN
      frame   <= frame_n;
      nbits   <= nbits_n;
      retry   <= retry_n;
`endif
    end
  end

  assign up.in_ready     = ready_q;
  assign swim_drive_low  = drive_q;
  assign done            = done_q;
  assign ack_ok          = ack_q;
  assign timeout         = to_q;
  assign busy            = (state != S_IDLE);
`ifdef SWIM_TX_RETRY_EN
  assign retry_cnt       = retry;
`endif

endmodule

// File: tb/tb_swim_byte_tx.sv
// Directed bench for the SWIM byte transmitter with an open-drain target model.
// Optional resend-on-NACK support is enabled with SWIM_TX_RETRY_EN.
module tb_swim_byte_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tgt_low = 1'b0;
  logic swim_drive_low, swim_in;
  logic done, ack_ok, timeout, busy;
`ifdef SWIM_TX_RETRY_EN
  logic [1:0] retry_cnt;
  localparam int NACK_TRIES = 4;
`else
  localparam int NACK_TRIES = 1;
`endif

  always #5 clk = ~clk;

  swim_byte_tx_if up ();

  assign swim_in = ~(swim_drive_low | tgt_low);

  swim_byte_tx dut (
    .clk            (clk),
    .reset          (reset),
    .up             (up),
    .swim_drive_low (swim_drive_low),
    .swim_in        (swim_in),
    .done           (done),
    .ack_ok         (ack_ok),
    .timeout        (timeout),
`ifdef SWIM_TX_RETRY_EN
    .retry_cnt      (retry_cnt),
`endif
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int widths[$];
  int starts[$];
  int run = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int bad_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (swim_drive_low) begin
      if (run == 0) starts.push_back(cyc);
      run++;
    end else if (run > 0) begin
      widths.push_back(run);
      run = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && up.in_ready) bad_ready++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected low width of slot i, built from header/payload/parity.
  function automatic int exp_w(input logic [7:0] d, input logic c,
                               input int i);
    int len;
    int ones;
    logic b;
    len = c ? 3 : 8;
    ones = 0;
    for (int k = 0; k < len; k++) ones += d[k];
    if (i == 0) b = 1'b0;
    else if (i <= len) b = d[len - i];
    else b = ones[0];
    return b ? 12 : 120;
  endfunction

  task automatic send(input logic [7:0] d, input logic c);
    int g;
    g = 0;
    @(negedge clk);
    while (!up.in_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("ready_wait", int'(up.in_ready), 1);
    up.in_data  = d;
    up.in_cmd   = c;
    up.in_valid = 1'b1;
    @(negedge clk);
    up.in_valid = 1'b0;
  endtask

  task automatic respond(input int n, input int base, input int tries,
                         input int nack_low, input int final_low);
    int g;
    int lw;
    for (int k = 0; k < tries; k++) begin
      g = 0;
      while (widths.size() < base + n * (k + 1) && g < 5000) begin
        @(negedge clk);
        g++;
      end
      chk("frame_wait", int'(g < 5000), 1);
      lw = (k == tries - 1) ? final_low : nack_low;
      repeat (130) @(negedge clk);
      tgt_low = 1'b1;
      repeat (lw) @(negedge clk);
      tgt_low = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d,
                           input logic c, input int frames,
                           input int tries, input int nack_low,
                           input int final_low, input int exp_ack,
                           input int exp_to);
    int n, base, sbase, pd, g;
    n = c ? 5 : 10;
    base = widths.size();
    sbase = starts.size();
    pd = done_cnt;
    send(d, c);
    if (tries > 0) respond(n, base, tries, nack_low, final_low);
    g = 0;
    while (done_cnt == pd && g < 6000) begin
      @(negedge clk);
      g++;
    end
    repeat (5) @(negedge clk);
    chk({tag, "_done"}, done_cnt - pd, 1);
    chk({tag, "_slots"}, widths.size() - base, n * frames);
    for (int i = 0; i < n; i++)
      if (widths.size() > base + i)
        chk({tag, "_w"}, widths[base + i], exp_w(d, c, i));
    chk({tag, "_ack"}, int'(ack_ok), exp_ack);
    chk({tag, "_to"}, int'(timeout), exp_to);
    chk({tag, "_rdy"}, bad_ready, 0);
    if (exp_to == 1 && starts.size() > sbase)
      chk({tag, "_tlat"}, done_cyc - starts[sbase], 132 * n + 2048);
  endtask

  initial begin
    int g, pd;
    up.in_data  = 8'h00;
    up.in_cmd   = 1'b0;
    up.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_drive", int'(swim_drive_low), 0);
    chk("rst_ready", int'(up.in_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack_ok), 0);
    chk("rst_to", int'(timeout), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(up.in_ready), 1);

    run_frame("d00", 8'h00, 1'b0, 1, 1, 120, 12, 1, 0);
    run_frame("srst", 8'h01, 1'b1, 1, 1, 120, 12, 1, 0);
    run_frame("dA5", 8'hA5, 1'b0, NACK_TRIES, NACK_TRIES, 120, 120, 0, 0);
`ifdef SWIM_TX_RETRY_EN
    chk("dA5_retry", int'(retry_cnt), 3);
`endif
    run_frame("tmo", 8'h3C, 1'b0, 1, 0, 0, 0, 0, 1);

    pd = done_cnt;
    send(8'hA5, 1'b0);
    g = 0;
    while (run < 50 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("mid_reach", int'(g < 1000), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_drive", int'(swim_drive_low), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_ready", int'(up.in_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_ready_up", int'(up.in_ready), 1);
    repeat (300) @(negedge clk);
    chk("mid_nodone", done_cnt - pd, 0);
    chk("mid_line", int'(swim_drive_low), 0);

`ifdef SWIM_TX_RETRY_EN
    run_frame("retry", 8'h5A, 1'b0, 3, 3, 120, 12, 1, 0);
    chk("retry_cnt", int'(retry_cnt), 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swim_byte_tx.md
Name: swim_byte_tx

Overview:
- Frames SWIM low-speed host-to-target transfers on the open-drain SWIM line.
- Consumes the byte stream coming out of the USB UART/FIFO path via a valid/ready handshake.
- Emits each command or data frame as pulse-width-coded bits, then samples the target's ACK bit.
- Runs after the SWIM entry/reset sequencer has put the target in SWIM mode; reports ACK/NACK status back upstream for return over USB.

Parameters:
- CLKS_PER_SWIM, 6, clk cycles per SWIM clock (48 MHz / 8 MHz)
- BIT_SWIM, 22, SWIM clocks per bit slot
- SHORT_SWIM, 2, SWIM clocks of low time for a '1' bit
- ACK_TIMEOUT, 2048, clk cycles to wait for the target ACK falling edge

Ports:
- clk  in  1  system clock, 48 MHz
- reset  in  1  synchronous, active-high
- in_data  in  8  command (bits [2:0]) or data byte
- in_cmd  in  1  1 = 3-bit command frame, 0 = 8-bit data frame
- in_valid  in  1  upstream holds in_data/in_cmd stable while high
- in_ready  out  1  high only in IDLE
- swim_drive_low  out  1  1 = pull line low (drives SB_IO OUTPUT_ENABLE, D_OUT=0)
- swim_in  in  1  raw line level, asynchronous
- done  out  1  one-cycle pulse when a frame completes
- ack_ok  out  1  valid with done: 1 = ACK, 0 = NACK or timeout
- timeout  out  1  valid with done: 1 = no ACK edge seen
- busy  out  1  high whenever not IDLE

Behaviour:
- Reset values: swim_drive_low=0, in_ready=0 for the reset cycle, then 1; done=0, ack_ok=0, timeout=0, busy=0.
- Reset mid-frame aborts immediately and releases the line in the same cycle it is sampled.
- swim_in passes through a 2-flop synchronizer; all sampling uses the synchronized value, which lags by 2 cycles.
- Handshake:
  - Transfer occurs on in_valid && in_ready.
  - The byte and in_cmd are latched into a shift register.
  - Even parity is computed over the payload bits.
  - The FSM enters LOW on the next cycle; in_ready deasserts in that same cycle.
- Frame bit order:
  - Header bit '0'.
  - Payload MSB first: 3 bits for a command, 8 for data.
  - Parity bit.
  - Frame length is 5 bits for a command, 10 bits for data.
- Bit slot: T = BIT_SWIM*CLKS_PER_SWIM = 132 clk.
  - '0' bit: drive low for (BIT_SWIM-SHORT_SWIM)*CLKS_PER_SWIM = 120 clk, then release for 12 clk.
  - '1' bit: drive low for 12 clk, then release for 120 clk.
  - Slots are back-to-back with no gap.
- States:
  - IDLE -> LOW on accept.
  - LOW -> HIGH when the low counter expires.
  - HIGH -> LOW when the slot ends and bits remain.
  - HIGH -> ACK_WAIT after the final slot.
  - ACK_WAIT -> ACK_LOW on a synchronized falling edge, or -> DONE with timeout=1 after ACK_TIMEOUT clk.
  - ACK_LOW counts low clk until the synchronized line rises:
    - count < 11*CLKS_PER_SWIM (66) gives ACK (bit '1').
    - otherwise NACK.
    - If the line is still low at T clk, the result is NACK and the FSM goes to DONE.
  - DONE: pulse done for one cycle, then return to IDLE.
- The line is released (swim_drive_low=0) throughout ACK_WAIT, ACK_LOW, DONE and IDLE.
- ack_ok and timeout hold their value until the next done.
- Counters must not wrap:
  - Slot counter is 8 bits.
  - Timeout counter is clog2(ACK_TIMEOUT)+1 bits.
- in_valid arriving while busy is ignored (ready is low); the data must be held by upstream.
- A line glitch during transmit (e.g. target pulling low) is not checked.

Optional Feature:
- SWIM_TX_RETRY_EN, when defined:
  - On NACK (not timeout), the latched frame is resent up to 3 extra times.
  - A 132-clk released gap precedes each retry.
  - done/ack_ok report only the final attempt.
  - A retry_cnt[1:0] output reports the attempts used.
- When undefined: no retry, no retry_cnt port, and NACK is reported on the first attempt.

Decomposition:
- swim_pkg holds the state encoding (IDLE, LOW, HIGH, ACK_WAIT, ACK_LOW, DONE), the frame lengths (5/10), the ACK threshold (11) and default timing constants.
- Sub-module swim_sync: 2-flop synchronizer plus falling/rising edge detect, reused later by the SWIM receive path.

Test Plan:
- Data 0x00, in_cmd=0, target model ACKs with 12-clk low:
  - Header+8x'0'+parity'0' = 10 slots, each 120 low / 12 high.
  - done at ~1320+ACK clk with ack_ok=1.
- Command 3'b001 (SRST), in_cmd=1:
  - Bits 0,0,0,1, parity 1.
  - Low widths 120,120,120,12,12.
  - in_ready low for the whole frame.
- Data 0xA5, target holds ACK low 120 clk -> done with ack_ok=0, timeout=0.
- No target response -> done exactly ACK_TIMEOUT clk after ACK_WAIT entry, with timeout=1 and ack_ok=0.
- Assert reset at clk 50 of a '0' low phase:
  - swim_drive_low=0 the next cycle.
  - in_ready=1 after reset.
  - No done pulse.
- With SWIM_TX_RETRY_EN, target NACKs twice then ACKs -> 3 frames on the wire, single done with ack_ok=1, retry_cnt=2.
